// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared types and width helper for the button debouncer
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Counter width that never collapses to zero bits for tiny terminal counts.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// rtl/btn_debounce_chan.sv - one channel: synchroniser, debounce counter, edge strobes, auto-repeat
module btn_debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    input  logic i_rep_en,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_rep
);

    localparam int DB_W    = clog2_min1(STABLE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = clog2_min1(RPT_MAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_rep;
    logic [RPT_W-1:0]       r_rpt_cnt;
    rpt_state_t             r_state;
    rpt_state_t             w_state_nxt;

    logic w_in;
    logic w_s;
    logic w_diff;
    logic w_done;
    logic w_level_nxt;
    logic w_rise_evt;
    logic w_hold;
    logic w_delay_tc;
    logic w_rate_tc;
    logic w_rep_pulse;
    logic w_cnt_clr;

    assign w_in        = ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_diff      = w_s ^ r_level;
    assign w_done      = w_diff && (r_db_cnt == DB_W'(STABLE_CYCLES - 1));
    assign w_level_nxt = r_level ^ w_done;
    assign w_rise_evt  = w_done & ~r_level;
    // Repeat logic looks at the level being registered this edge so the
    // release edge itself can never carry a repeat strobe.
    assign w_hold      = w_level_nxt & i_rep_en;
    assign w_delay_tc  = (r_rpt_cnt == RPT_W'(REPEAT_DELAY - 1));
    assign w_rate_tc   = (r_rpt_cnt == RPT_W'(REPEAT_RATE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_db_cnt <= (w_diff && !w_done) ? r_db_cnt + 1'b1 : '0;
            r_level  <= w_level_nxt;
            r_rise   <= w_done & ~r_level;
            r_fall   <= w_done & r_level;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_rep     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_cnt_clr ? '0 : r_rpt_cnt + 1'b1;
            r_rep     <= w_rep_pulse;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_hold) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_rise_evt) w_state_nxt = DELAY;
                DELAY:   if (w_delay_tc) w_state_nxt = REPEAT;
                REPEAT:  w_state_nxt = REPEAT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_rep_pulse = 1'b0;
        w_cnt_clr   = 1'b1;
        if (w_hold) begin
            case (r_state)
                DELAY: begin
                    w_rep_pulse = w_delay_tc;
                    w_cnt_clr   = w_delay_tc;
                end
                REPEAT: begin
                    w_rep_pulse = w_rate_tc;
                    w_cnt_clr   = w_rate_tc;
                end
                default: begin
                    w_rep_pulse = 1'b0;
                    w_cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_rep   = r_rep;

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N independent debounced button channels with edge and repeat strobes
module btn_debounce_multi
    import btn_debounce_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                gclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic [CHANNELS-1:0] rep_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rep
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        btn_debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .i_clk    (gclk),
            .i_rst_n  (rst),
            .i_btn_raw(btn_raw[g]),
            .i_rep_en (rep_en[g]),
            .o_level  (level[g]),
            .o_rise   (rise[g]),
            .o_fall   (fall[g]),
            .o_rep    (rep[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - directed self-checking bench for btn_debounce_multi
module tb_btn_debounce_multi;

    logic       gclk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] rep_en;
    logic [3:0] level, rise, fall, rep;

    logic [3:0] raw_n;
    logic [3:0] rep_en_al;
    logic [3:0] level_al, rise_al, fall_al, rep_al;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 gclk = ~gclk;

    btn_debounce_multi #(
        .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(1'b0)
    ) dut (
        .gclk(gclk), .rst(rst), .btn_raw(btn_raw), .rep_en(rep_en),
        .level(level), .rise(rise), .fall(fall), .rep(rep)
    );

    btn_debounce_multi #(
        .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .gclk(gclk), .rst(rst), .btn_raw(raw_n), .rep_en(rep_en_al),
        .level(level_al), .rise(rise_al), .fall(fall_al), .rep(rep_al)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_rep;
        rst       = 1'b0;
        btn_raw   = 4'b0000;
        rep_en    = 4'b0000;
        raw_n     = 4'b1111;
        rep_en_al = 4'b0000;
        #1;
        chk("reset_level", level, 4'b0000);
        chk("reset_strobes", rise | fall | rep, 4'b0000);
        chk("reset_level_al", level_al, 4'b0000);
        tick(2);
        rst = 1'b1;
        tick(3);
        chk("post_reset_level", level, 4'b0000);
        chk("post_reset_rise", rise, 4'b0000);
        chk("post_reset_al", level_al | rise_al, 4'b0000);

        // clean press on channel 0
        btn_raw[0] = 1'b1;
        tick(5);
        chk("press_early_level", level, 4'b0000);
        tick(1);
        chk("press_level", level, 4'b0001);
        chk("press_rise", rise, 4'b0001);
        tick(1);
        chk("press_rise_one_cycle", rise, 4'b0000);
        chk("press_level_hold", level, 4'b0001);

        // 3-cycle glitch on channel 1 is rejected
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_quiet", {1'b0, level[1], rise[1], fall[1]}, 4'b0000);
        end

        // 4-cycle pulse on channel 1 is accepted, then released
        btn_raw[1] = 1'b1;
        tick(4);
        btn_raw[1] = 1'b0;
        tick(2);
        chk("pulse4_level", level, 4'b0011);
        chk("pulse4_rise", rise, 4'b0010);
        tick(3);
        chk("release_early_fall", fall, 4'b0000);
        tick(1);
        chk("release_fall", fall, 4'b0010);
        chk("release_level", level, 4'b0001);
        tick(1);
        chk("release_fall_one_cycle", fall, 4'b0000);

        // auto-repeat on channel 2: reps at rise+10, +13, +16, ...
        rep_en[2]  = 1'b1;
        btn_raw[2] = 1'b1;
        tick(6);
        chk("rpt_rise", rise, 4'b0100);
        chk("rpt_rise_no_rep", rep, 4'b0000);
        for (int i = 1; i <= 45; i++) begin
            tick(1);
            exp_rep = (i >= 10 && i < 40 && ((i - 10) % 3) == 0) ? 4'b0100 : 4'b0000;
            chk($sformatf("rpt_cycle_%0d", i), rep, exp_rep);
            if (i == 40) begin
                chk("rpt_release_fall", fall, 4'b0100);
                chk("rpt_release_level", level, 4'b0001);
            end
            if (i == 34) btn_raw[2] = 1'b0;
        end

        // disabling repeat one cycle before a scheduled rep suppresses it for good
        btn_raw[2] = 1'b1;
        tick(6);
        chk("dis_rise", rise, 4'b0100);
        tick(9);
        chk("dis_before", rep, 4'b0000);
        rep_en[2] = 1'b0;
        tick(1);
        chk("dis_suppressed", rep, 4'b0000);
        rep_en[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("dis_no_resume", rep, 4'b0000);
        end
        btn_raw[2] = 1'b0;
        tick(6);
        chk("dis_release_fall", fall, 4'b0100);

        // asynchronous reset while channel 3 is held
        btn_raw[3] = 1'b1;
        tick(6);
        chk("rst_pre_level", level, 4'b1001);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_level", level, 4'b0000);
        chk("rst_async_strobes", rise | fall | rep, 4'b0000);
        tick(1);
        chk("rst_hold_level", level, 4'b0000);
        rst = 1'b1;
        tick(5);
        chk("rst_exit_early", level | rise, 4'b0000);
        tick(1);
        chk("rst_exit_level", level, 4'b1001);
        chk("rst_exit_rise", rise, 4'b1001);
        chk("rst_exit_al_quiet", level_al, 4'b0000);

        // active-low instance, clean press on channel 0
        raw_n[0] = 1'b0;
        tick(5);
        chk("al_early_level", level_al, 4'b0000);
        tick(1);
        chk("al_level", level_al, 4'b0001);
        chk("al_rise", rise_al, 4'b0001);
        tick(1);
        chk("al_rise_one_cycle", rise_al, 4'b0000);
        raw_n[0] = 1'b1;
        tick(6);
        chk("al_fall", fall_al, 4'b0001);
        chk("al_fall_level", level_al, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel successor to the single-button dejitter path.
- Synchronises and debounces CHANNELS raw board inputs (buttons/switches) on the board clock gclk.
- Per channel it produces a clean level, one-cycle rise and fall strobes, and an optional auto-repeat strobe.
- Sits between board pins and `top`. Outputs are data strobes, not derived clocks.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- STABLE_CYCLES, 50000, consecutive cycles a new synchronised level must persist before acceptance (>=2).
- REPEAT_DELAY, 25000000, cycles of held-active level before the first repeat strobe (>=2).
- REPEAT_RATE, 5000000, cycles between subsequent repeat strobes (>=2).
- ACTIVE_LOW, 0, 1 = raw inputs are active-low and are inverted before synchronisation.

Ports:
- gclk  in  1  board clock; only clock in the block.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  CHANNELS  raw asynchronous pin inputs.
- rep_en  in  CHANNELS  per-channel auto-repeat enable (synchronous to gclk).
- level  out  CHANNELS  debounced active-high level.
- rise  out  CHANNELS  1-cycle strobe when level goes 0->1.
- fall  out  CHANNELS  1-cycle strobe when level goes 1->0.
- rep  out  CHANNELS  1-cycle auto-repeat strobe.

Behaviour:
- Reset (rst=0, asynchronous): all synchroniser flops, counters, level, rise, fall and rep go to 0 immediately. Synchroniser flops hold the inactive level, so release from reset produces no spurious rise.
- Polarity: in = ACTIVE_LOW ? ~btn_raw : btn_raw. Then SYNC_STAGES flops give s.
- Debounce counter: width $clog2(STABLE_CYCLES).
  - s == level: counter cleared to 0.
  - s != level: counter increments.
  - On the cycle the counter equals STABLE_CYCLES-1 with s != level: level toggles and the counter clears.
  - A single-cycle glitch back to the old level clears the counter, so the count restarts from 0.
- Latency: from a raw edge held steady, level changes SYNC_STAGES+STABLE_CYCLES gclk edges later.
- Strobes: rise/fall are registered and asserted in the same cycle level updates, for exactly one cycle. rise and fall are never both high.
- Repeat FSM (per channel):
  - States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on rise when rep_en=1; repeat counter cleared.
  - DELAY: count. At REPEAT_DELAY-1, pulse rep, clear counter, go to REPEAT.
  - REPEAT: count. At REPEAT_RATE-1, pulse rep and clear counter. Wraps indefinitely.
  - Any state -> IDLE (counter cleared, no rep) when level=0 or rep_en=0. This exit has priority over the terminal-count pulse in the same cycle.
  - rise itself never coincides with rep. The first rep comes REPEAT_DELAY cycles after rise.
  - Repeat counter width: $clog2(max(REPEAT_DELAY, REPEAT_RATE)).
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset asserted mid-debounce or mid-repeat aborts it and clears all state. No strobe is emitted on reset entry or exit.

Decomposition:
- Package btn_debounce_pkg: repeat FSM state enum (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2), and a width function clog2_min1 (returns at least 1).
- Sub-module btn_debounce_chan: one channel containing the synchroniser, debounce counter, edge strobes and repeat FSM. The top module instantiates it CHANNELS times in a generate loop, with no other logic.

Test Plan:
- Bench parameters: CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=0.
- Clean press: btn_raw[0] 0->1 held -> level[0]=1 and rise[0]=1 exactly 6 edges later, rise for 1 cycle; other channels stay 0.
- Glitch rejection: btn_raw[1] high for 3 cycles then low -> level[1], rise[1] and fall[1] never assert. High for 4 cycles -> level[1] rises, and after release fall[1] pulses 6 edges after the release.
- Auto-repeat: rep_en[2]=1, btn_raw[2] held 40 cycles -> rep[2] at rise+10, +13, +16, ... On release, no rep after level drops.
- Repeat disable: rep_en[2] cleared 1 cycle before a scheduled rep -> that rep is suppressed, FSM returns to IDLE, and re-enabling while held does not resume repeats.
- Async reset mid-hold: drop rst between gclk edges while level[3]=1 -> all outputs 0 immediately. Release rst with btn_raw[3]=1 -> rise[3] 6 edges after the release edge.
- ACTIVE_LOW=1 rerun of the clean-press scenario with the input inverted -> identical timing.
